// File: rtl/ram_writer.sv
// Packet-to-RAM writer: buffers one AXI-Stream packet and stores it from
// address 0 as CPB-beat AXI4 INCR bursts, then reports the packet geometry.
module ram_writer #(
  parameter int DW         = 512,
  parameter int IW         = 5,
  parameter int CPB        = 64,
  parameter int FIFO_DEPTH = 2*CPB
) (
  input  logic            clk,
  input  logic            reset,

  input  logic [DW-1:0]   AXIS_IN_TDATA,
  input  logic            AXIS_IN_TVALID,
  input  logic            AXIS_IN_TLAST,
  output logic            AXIS_IN_TREADY,

  output logic [31:0]     full_blocks,
  output logic [7:0]      partial_block_cycles,
  output logic            done,
  output logic            idle,
  output logic            error,

  output logic [63:0]     M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [IW-1:0]   M_AXI_AWID,
  output logic [1:0]      M_AXI_AWBURST,
  output logic            M_AXI_AWLOCK,
  output logic [3:0]      M_AXI_AWCACHE,
  output logic [3:0]      M_AXI_AWQOS,
  output logic [2:0]      M_AXI_AWPROT,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,

  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WVALID,
  output logic            M_AXI_WLAST,
  input  logic            M_AXI_WREADY,

  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,

  output logic [63:0]     M_AXI_ARADDR,
  output logic [7:0]      M_AXI_ARLEN,
  output logic [2:0]      M_AXI_ARSIZE,
  output logic [IW-1:0]   M_AXI_ARID,
  output logic [1:0]      M_AXI_ARBURST,
  output logic            M_AXI_ARLOCK,
  output logic [3:0]      M_AXI_ARCACHE,
  output logic [3:0]      M_AXI_ARQOS,
  output logic [2:0]      M_AXI_ARPROT,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,

  input  logic [DW-1:0]   M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RLAST,
  input  logic            M_AXI_RVALID,
  input  logic [IW-1:0]   M_AXI_RID,
  output logic            M_AXI_RREADY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [63:0]   BURST_BYTES = 64'(CPB * DW / 8);
  localparam logic [CW-1:0] CPB_CNT     = CW'(CPB);
  localparam logic [CW-1:0] DEPTH_CNT   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  localparam logic [8:0]    CPB_LEN     = 9'(CPB);
  localparam logic [7:0]    CPB_AWLEN   = 8'(CPB - 1);
  localparam logic [2:0]    SIZE_C      = 3'($clog2(DW / 8));

  typedef enum logic [1:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B
  } state_t;

  state_t state;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  logic          tlast_seen;
  logic [8:0]    burst_len;
  logic [8:0]    w_cnt;
  logic [31:0]   full_cnt;
  logic [7:0]    partial_cnt;
  logic          aw_valid;
  logic          b_ready;
  logic [63:0]   aw_addr;
  logic [7:0]    aw_len;
  logic          w_valid;
  logic          w_last;
  logic          last_full;
  logic          pkt_end;

  assign fifo_full  = (fifo_count == DEPTH_CNT);
  assign fifo_empty = (fifo_count == '0);

  assign AXIS_IN_TREADY = ~fifo_full & ~tlast_seen;
  assign push = AXIS_IN_TVALID & AXIS_IN_TREADY;

  assign w_valid = (state == S_W) & ~fifo_empty;
  assign w_last  = (state == S_W) & (w_cnt == burst_len - 9'd1);
  assign pop     = w_valid & M_AXI_WREADY;

  always_comb begin
    count_next = fifo_count;
    case ({push, pop})
      2'b10:   count_next = fifo_count + CNT_ONE;
      2'b01:   count_next = fifo_count - CNT_ONE;
      default: count_next = fifo_count;
    endcase
  end

  // Completion uses the post-cycle fill level so a beat landing now counts.
  assign last_full = (burst_len == CPB_LEN);
  assign pkt_end   = tlast_seen & (count_next == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= AXIS_IN_TDATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= S_IDLE;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      fifo_count           <= '0;
      tlast_seen           <= 1'b0;
      burst_len            <= '0;
      w_cnt                <= '0;
      full_cnt             <= '0;
      partial_cnt          <= '0;
      aw_valid             <= 1'b0;
      b_ready              <= 1'b0;
      aw_addr              <= '0;
      aw_len               <= '0;
      done                 <= 1'b0;
      error                <= 1'b0;
      full_blocks          <= '0;
      partial_block_cycles <= '0;
    end else begin
      done       <= 1'b0;
      fifo_count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (AXIS_IN_TLAST) begin
          tlast_seen <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      unique case (state)
        S_IDLE: begin
          if (fifo_count >= CPB_CNT) begin
            burst_len <= CPB_LEN;
            aw_len    <= CPB_AWLEN;
            aw_valid  <= 1'b1;
            state     <= S_AW;
          end else if (tlast_seen && !fifo_empty) begin
            burst_len <= 9'(fifo_count);
            aw_len    <= 8'(fifo_count - CNT_ONE);
            aw_valid  <= 1'b1;
            state     <= S_AW;
          end
        end
        S_AW: begin
          if (M_AXI_AWREADY) begin
            aw_valid <= 1'b0;
            w_cnt    <= '0;
            state    <= S_W;
          end
        end
        S_W: begin
          if (pop) begin
            w_cnt <= w_cnt + 9'd1;
            if (w_last) begin
              b_ready <= 1'b1;
              state   <= S_B;
            end
          end
        end
        S_B: begin
          if (M_AXI_BVALID) begin
            b_ready <= 1'b0;
            state   <= S_IDLE;
            if (M_AXI_BRESP != 2'b00) begin
              error <= 1'b1;
            end
            if (pkt_end) begin
              done        <= 1'b1;
              full_blocks <= full_cnt + {31'b0, last_full};
              partial_block_cycles <=
                last_full ? partial_cnt : burst_len[7:0];
              full_cnt    <= '0;
              partial_cnt <= '0;
              tlast_seen  <= 1'b0;
              aw_addr     <= '0;
            end else begin
              if (last_full) begin
                full_cnt <= full_cnt + 32'd1;
              end else begin
                partial_cnt <= burst_len[7:0];
              end
              aw_addr <= aw_addr + BURST_BYTES;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign idle = (state == S_IDLE) & ~tlast_seen & fifo_empty & ~done;

  assign M_AXI_AWADDR  = aw_addr;
  assign M_AXI_AWLEN   = aw_len;
  assign M_AXI_AWSIZE  = SIZE_C;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = '0;
  assign M_AXI_AWQOS   = '0;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWVALID = aw_valid;

  assign M_AXI_WDATA  = mem[rd_ptr];
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_WVALID = w_valid;
  assign M_AXI_WLAST  = w_last;
  assign M_AXI_BREADY = b_ready;

  // Write-only master: the read channels are parked.
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARLEN   = '0;
  assign M_AXI_ARSIZE  = '0;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARBURST = '0;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARQOS   = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;

  logic unused_rd;
  assign unused_rd = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP,
                       M_AXI_RLAST, M_AXI_RVALID, M_AXI_RID};

endmodule

// File: tb/tb_ram_writer.sv
// Bench for ram_writer: random packets into a reactive AXI slave with a
// RAM model; results compared with geometry derived from packet length.
module tb_ram_writer;
  localparam int DW  = 512;
  localparam int IW  = 5;
  localparam int CPB = 64;
  localparam int BPB = DW / 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]   tdata = '0;
  logic            tvalid = 1'b0;
  logic            tlast = 1'b0;
  logic            tready;
  logic [31:0]     full_blocks;
  logic [7:0]      partial_block_cycles;
  logic            done, idle, error;
  logic [63:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [IW-1:0]   awid;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache, awqos;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready = 1'b1;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid, wlast;
  logic            wready = 1'b1;
  logic [1:0]      bresp = 2'b00;
  logic            bvalid = 1'b0;
  logic            bready;
  logic [63:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [IW-1:0]   arid;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache, arqos;
  logic [2:0]      arprot;
  logic            arvalid, rready;

  ram_writer #(.DW(DW), .IW(IW), .CPB(CPB), .FIFO_DEPTH(2*CPB)) dut (
    .clk(clk), .reset(reset),
    .AXIS_IN_TDATA(tdata), .AXIS_IN_TVALID(tvalid),
    .AXIS_IN_TLAST(tlast), .AXIS_IN_TREADY(tready),
    .full_blocks(full_blocks),
    .partial_block_cycles(partial_block_cycles),
    .done(done), .idle(idle), .error(error),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWID(awid), .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock),
    .M_AXI_AWCACHE(awcache), .M_AXI_AWQOS(awqos), .M_AXI_AWPROT(awprot),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WLAST(wlast), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARID(arid), .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock),
    .M_AXI_ARCACHE(arcache), .M_AXI_ARQOS(arqos), .M_AXI_ARPROT(arprot),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(1'b0),
    .M_AXI_RDATA('0), .M_AXI_RRESP(2'b00), .M_AXI_RLAST(1'b0),
    .M_AXI_RVALID(1'b0), .M_AXI_RID('0), .M_AXI_RREADY(rready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } aw_t;

  int n_chk = 0;
  int n_bad = 0;

  beat_t         send_q[$];
  logic [DW-1:0] exp_q[$];
  aw_t           aw_q[$];
  int            wlast_q[$];
  logic [DW-1:0] ram[int];

  bit w_rand = 0;
  bit aw_delay = 0;
  int err_burst = 0;
  int aw_wait = 0;
  bit b_pend = 0;
  int b_num = 0;
  int occ = 0;
  bit tlast_acc = 0;
  int cur_base = 0;
  int cur_beat = 0;
  int pkt_wbeats = 0;
  int done_cnt = 0;
  bit prev_done = 0;
  logic idle_after = 1'b0;
  int tready_bad = 0;
  int const_bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Slave + monitor: drive at negedge, observe handshakes 1 ns later.
  initial begin
    forever begin
      @(negedge clk);
      if (send_q.size() > 0) begin
        tvalid = 1'b1;
        tdata  = send_q[0].data;
        tlast  = send_q[0].last;
      end else begin
        tvalid = 1'b0;
        tdata  = '0;
        tlast  = 1'b0;
      end
      awready = aw_delay ? (aw_wait >= 3) : 1'b1;
      wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = b_pend;
      bresp   = (b_pend && (b_num + 1 == err_burst)) ? 2'd2 : 2'd0;
      #1;
      if (reset) begin
        occ = 0; tlast_acc = 0; b_pend = 0; aw_wait = 0; prev_done = 0;
      end else begin
        if (done) begin
          done_cnt++;
          tlast_acc = 0;
        end
        if (prev_done) idle_after = idle;
        prev_done = done;
        if (tready !== ((occ < 2*CPB) && !tlast_acc)) tready_bad++;
        if (awvalid && !awready) aw_wait++;
        if (awvalid && awready) begin
          aw_q.push_back('{addr: awaddr, len: awlen});
          if (awsize !== 3'd6 || awburst !== 2'd1 || awid !== '0)
            const_bad++;
          cur_base = int'(awaddr / BPB);
          cur_beat = 0;
          aw_wait = 0;
        end
        if (wvalid && wready) begin
          ram[cur_base + cur_beat] = wdata;
          cur_beat++;
          pkt_wbeats++;
          occ--;
          if (wstrb !== '1) const_bad++;
          if (wlast) wlast_q.push_back(pkt_wbeats);
        end
        if (tvalid && tready) begin
          if (tlast) tlast_acc = 1;
          occ++;
          void'(send_q.pop_front());
        end
        if (bvalid && bready) begin
          b_pend = 0;
          b_num++;
        end
        if (wvalid && wready && wlast) b_pend = 1;
      end
    end
  end

  task automatic clear_pkt();
    aw_q.delete(); wlast_q.delete(); ram.delete(); exp_q.delete();
    pkt_wbeats = 0; b_num = 0; done_cnt = 0;
    idle_after = 1'b0; tready_bad = 0; const_bad = 0;
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = rand_word();
      b.last = (i == n - 1);
      send_q.push_back(b);
      exp_q.push_back(b.data);
    end
  endtask

  task automatic run_pkt(input string name, input int n);
    int c, bad, nf, np, nb;
    clear_pkt();
    send_pkt(n);
    c = 0;
    while (done_cnt == 0 && c < 4000) begin
      @(negedge clk); #2; c++;
    end
    check({name, ".done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) begin @(negedge clk); #2; end
    nf = n / CPB;
    np = n % CPB;
    nb = nf + ((np > 0) ? 1 : 0);
    check({name, ".done_cnt"}, 64'(done_cnt), 64'd1);
    check({name, ".full_blocks"}, 64'(full_blocks), 64'(nf));
    check({name, ".partial"}, 64'(partial_block_cycles), 64'(np));
    check({name, ".aw_count"}, 64'(aw_q.size()), 64'(nb));
    bad = const_bad;
    for (int i = 0; i < aw_q.size(); i++) begin
      if (aw_q[i].addr !== 64'(i * CPB * BPB)) bad++;
      if (aw_q[i].len !== 8'((i < nf) ? CPB - 1 : np - 1)) bad++;
    end
    check({name, ".aw_fields"}, 64'(bad), 64'd0);
    bad = (ram.num() != n) ? 1 : 0;
    for (int i = 0; i < n; i++)
      if (!ram.exists(i) || ram[i] !== exp_q[i]) bad++;
    check({name, ".ram_data"}, 64'(bad), 64'd0);
    bad = (wlast_q.size() != nb) ? 1 : 0;
    for (int i = 0; i < wlast_q.size(); i++)
      if (wlast_q[i] != ((i < nf) ? (i + 1) * CPB : n)) bad++;
    check({name, ".wlast_pos"}, 64'(bad), 64'd0);
    check({name, ".idle_after_done"}, 64'(idle_after), 64'd1);
    check({name, ".tready_rule"}, 64'(tready_bad), 64'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    send_q.delete();
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    #2;
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    check("rst.awvalid", 64'(awvalid), 64'd0);
    check("rst.wvalid", 64'(wvalid), 64'd0);
    check("rst.bready", 64'(bready), 64'd0);
    check("rst.tready", 64'(tready), 64'd1);
    check("rst.done", 64'(done), 64'd0);
    check("rst.error", 64'(error), 64'd0);
    check("rst.full_blocks", 64'(full_blocks), 64'd0);
    check("rst.partial", 64'(partial_block_cycles), 64'd0);
    check("rst.idle", 64'(idle), 64'd1);
    check("rst.awaddr", awaddr, 64'd0);
    check("rst.awsize", 64'(awsize), 64'd6);
    check("rst.awburst", 64'(awburst), 64'd1);
    check("rst.arvalid", 64'(arvalid), 64'd0);

    run_pkt("t1_128", 128);
    run_pkt("t2_70", 70);
    run_pkt("t3_5", 5);
    check("t3.error", 64'(error), 64'd0);

    w_rand = 1; aw_delay = 1;
    run_pkt("t4_200", 200);
    w_rand = 0; aw_delay = 0;

    err_burst = 2;
    run_pkt("t5_100", 100);
    err_burst = 0;
    check("t5.error_set", 64'(error), 64'd1);

    clear_pkt();
    send_pkt(128);
    c = 0;
    while (pkt_wbeats < 30 && c < 2000) begin
      @(negedge clk); #2; c++;
    end
    check("t6.w30_reached", 64'(pkt_wbeats), 64'd30);
    check("t6.error_held", 64'(error), 64'd1);
    do_reset(1);
    check("t6.awvalid", 64'(awvalid), 64'd0);
    check("t6.wvalid", 64'(wvalid), 64'd0);
    check("t6.bready", 64'(bready), 64'd0);
    check("t6.tready", 64'(tready), 64'd1);
    check("t6.done", 64'(done), 64'd0);
    check("t6.error", 64'(error), 64'd0);
    check("t6.full_blocks", 64'(full_blocks), 64'd0);
    check("t6.partial", 64'(partial_block_cycles), 64'd0);
    check("t6.awaddr", awaddr, 64'd0);
    run_pkt("t6_10", 10);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
